// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_fwft family: read-mode encodings and
// a constant-evaluable ceiling log2 used to size pointers and the count.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2; clog2(1) = 0. Usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_fwft. Synchronous write port; the read port is
// combinational in FWFT mode so the head entry is always visible, and
// registered (loaded only on a read enable) in standard mode.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 8,
  parameter int fwft  = FIFO_MODE_STD,
  localparam int AW   = clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  // Write port: storage itself is never reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (fwft == FIFO_MODE_FWFT) begin : g_async_rd
    // Head entry falls through; the top masks it while the FIFO is empty.
    assign rdata = mem[raddr];

    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{reset, re};
  end else begin : g_reg_rd
    // Registered read: holds its value between accepted pops.
    always_ff @(posedge clk) begin
      if (!reset)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty
// thresholds, occupancy count and standard or first-word-fall-through reads.
// Optional feature macro: SYNC_FIFO_ERR_EN adds clr_err plus sticky
// overflow/underflow flags; without it illegal requests are silently ignored.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int width         = 8,
  parameter int depth         = 8,
  parameter int afull_thresh  = depth - 2,
  parameter int aempty_thresh = 1,
  parameter int fwft          = FIFO_MODE_STD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [width-1:0]            wr_data,
  input  logic                        pop,
  output logic [width-1:0]            rd_data,
  output logic                        empty,
  output logic                        full,
  output logic                        afull,
  output logic                        aempty,
  output logic [clog2(depth+1)-1:0]   count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                        clr_err,
  output logic                        overflow,
  output logic                        underflow
`endif
);

  localparam int CW = clog2(depth + 1);
  localparam int AW = clog2(depth);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic [width-1:0] ram_rdata;

  // Acceptance rules: a push into a full FIFO is fine when a pop frees a slot;
  // a pop from an empty FIFO is dropped even if a push lands the same cycle.
  always_comb begin
    push_ok   = push && (!full || pop);
    pop_ok    = pop && !empty;
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointers wrap by explicit compare so any depth works.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(depth - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == AW'(depth - 1)) ? '0 : rd_ptr + AW'(1);
    end
  end

  // Count and status flags are all registered from the next count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      count  <= count_nxt;
      empty  <= (count_nxt == '0);
      full   <= (count_nxt == CW'(depth));
      afull  <= (count_nxt >= CW'(afull_thresh));
      aempty <= (count_nxt <= CW'(aempty_thresh));
    end
  end

  sync_fifo_ram #(
    .width (width),
    .depth (depth),
    .fwft  (fwft)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok && reset),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (pop_ok && reset),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // In FWFT mode, force zero while empty so stale or uninitialised storage
  // never reaches the consumer.
  always_comb begin
    rd_data = ram_rdata;
    if (fwft == FIFO_MODE_FWFT && empty) rd_data = '0;
  end

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_err)         overflow <= 1'b0;
      if (pop && empty)         underflow <= 1'b1;
      else if (clr_err)         underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: one standard-mode and one FWFT instance (depth 5,
// afull_thresh 4, aempty_thresh 1) share the same stimulus. A queue models the
// FIFO contents; std-mode read data expected on each accepted pop is pushed to
// a scoreboard and popped when the registered rd_data should show it.
module tb_sync_fifo_fwft;

  localparam int DEPTH = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [7:0] wr_data;
  logic       pop;
  logic       clr_err;

  logic [7:0] s_rd, f_rd;
  logic       s_empty, s_full, s_afull, s_aempty;
  logic       f_empty, f_full, f_afull, f_aempty;
  logic [2:0] s_count, f_count;
  logic       s_ovf, s_unf, f_ovf, f_unf;

  int n_cmp = 0;
  int n_err = 0;

  bit [7:0] mdl[$];
  bit [7:0] sb_q[$];
  bit [7:0] last_rd;
  bit       exp_ovf, exp_unf;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.width(8), .depth(DEPTH), .afull_thresh(4), .aempty_thresh(1), .fwft(0)) dut_std (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(s_rd), .empty(s_empty), .full(s_full), .afull(s_afull), .aempty(s_aempty),
    .count(s_count)
`ifdef SYNC_FIFO_ERR_EN
    , .clr_err(clr_err), .overflow(s_ovf), .underflow(s_unf)
`endif
  );

  sync_fifo_fwft #(.width(8), .depth(DEPTH), .afull_thresh(4), .aempty_thresh(1), .fwft(1)) dut_fwft (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(f_rd), .empty(f_empty), .full(f_full), .afull(f_afull), .aempty(f_aempty),
    .count(f_count)
`ifdef SYNC_FIFO_ERR_EN
    , .clr_err(clr_err), .overflow(f_ovf), .underflow(f_unf)
`endif
  );

`ifndef SYNC_FIFO_ERR_EN
  assign s_ovf = 1'b0;
  assign s_unf = 1'b0;
  assign f_ovf = 1'b0;
  assign f_unf = 1'b0;
`endif

  // Expected {empty, full, afull, aempty, count} for occupancy n.
  function automatic logic [6:0] exp_status(input int n);
    logic [2:0] c;
    c = n[2:0];
    return {n == 0, n == DEPTH, n >= 4, n <= 1, c};
  endfunction

  // One clock of stimulus; updates the contents model and the scoreboard.
  task automatic drive(input bit p, input bit [7:0] d, input bit r);
    bit acc_push, acc_pop;
    int n;
    n = mdl.size();
    push = p; wr_data = d; pop = r;
    acc_pop  = r && (n != 0);
    acc_push = p && ((n < DEPTH) || r);
    if (p && n == DEPTH && !r) exp_ovf = 1'b1;
    else if (clr_err)          exp_ovf = 1'b0;
    if (r && n == 0)           exp_unf = 1'b1;
    else if (clr_err)          exp_unf = 1'b0;
    @(posedge clk); #1;
    if (acc_pop)  sb_q.push_back(mdl.pop_front());
    if (acc_push) mdl.push_back(d);
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic apply_reset(input int cycles, input bit with_traffic);
    reset = 1'b0;
    push = with_traffic; pop = with_traffic; wr_data = 8'h99;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1; push = 1'b0; pop = 1'b0;
    mdl.delete(); sb_q.delete();
    last_rd = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(3, 1'b1);
    n_cmp++;
    if ({s_empty, s_full, s_afull, s_aempty, s_count} !== exp_status(0)) begin
      n_err++; $display("FAIL reset_status_std: got %b want %b", {s_empty, s_full, s_afull, s_aempty, s_count}, exp_status(0));
    end
    n_cmp++;
    if ({f_empty, f_full, f_afull, f_aempty, f_count} !== exp_status(0)) begin
      n_err++; $display("FAIL reset_status_fwft: got %b want %b", {f_empty, f_full, f_afull, f_aempty, f_count}, exp_status(0));
    end
    n_cmp++;
    if (s_rd !== 8'h00 || f_rd !== 8'h00) begin
      n_err++; $display("FAIL reset_rd_data: got std %h fwft %h want 00", s_rd, f_rd);
    end
`ifdef SYNC_FIFO_ERR_EN
    n_cmp++;
    if ({s_ovf, s_unf, f_ovf, f_unf} !== 4'b0000) begin
      n_err++; $display("FAIL reset_err_flags: got %b want 0000", {s_ovf, s_unf, f_ovf, f_unf});
    end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      drive(1'b1, 8'(8'h11 * i), 1'b0);
      n_cmp++;
      if ({s_empty, s_full, s_afull, s_aempty, s_count} !== exp_status(mdl.size())) begin
        n_err++; $display("FAIL fill_status_std[%0d]: got %b want %b", i, {s_empty, s_full, s_afull, s_aempty, s_count}, exp_status(mdl.size()));
      end
      n_cmp++;
      if ({f_empty, f_full, f_afull, f_aempty, f_count} !== exp_status(mdl.size())) begin
        n_err++; $display("FAIL fill_status_fwft[%0d]: got %b want %b", i, {f_empty, f_full, f_afull, f_aempty, f_count}, exp_status(mdl.size()));
      end
      n_cmp++;
      if (f_rd !== 8'h11) begin
        n_err++; $display("FAIL fill_fwft_head[%0d]: got %h want 11", i, f_rd);
      end
    end
`ifdef SYNC_FIFO_ERR_EN
    n_cmp++;
    if (s_ovf !== exp_ovf || f_ovf !== exp_ovf || exp_ovf !== 1'b1) begin
      n_err++; $display("FAIL fill_overflow: got std %b fwft %b want 1", s_ovf, f_ovf);
    end
`endif
  endtask

  task automatic test_drain();
    bit [7:0] exp_d;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL drain_sb_empty[%0d]: got none want one", i);
      end else begin
        exp_d = sb_q.pop_front(); last_rd = exp_d;
        if (s_rd !== exp_d) begin
          n_err++; $display("FAIL drain_std_data[%0d]: got %h want %h", i, s_rd, exp_d);
        end
      end
      n_cmp++;
      if ({s_empty, s_full, s_afull, s_aempty, s_count} !== exp_status(mdl.size())) begin
        n_err++; $display("FAIL drain_status[%0d]: got %b want %b", i, {s_empty, s_full, s_afull, s_aempty, s_count}, exp_status(mdl.size()));
      end
      if (mdl.size() != 0) begin
        n_cmp++;
        if (f_rd !== mdl[0]) begin
          n_err++; $display("FAIL drain_fwft_head[%0d]: got %h want %h", i, f_rd, mdl[0]);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (s_rd !== last_rd || s_empty !== 1'b1 || s_count !== 3'd0) begin
      n_err++; $display("FAIL drain_extra_pop: got rd %h empty %b count %0d want %h 1 0", s_rd, s_empty, s_count, last_rd);
    end
`ifdef SYNC_FIFO_ERR_EN
    n_cmp++;
    if (s_unf !== exp_unf || f_unf !== exp_unf || exp_unf !== 1'b1) begin
      n_err++; $display("FAIL drain_underflow: got std %b fwft %b want 1", s_unf, f_unf);
    end
    clr_err = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (s_unf !== 1'b1 || s_ovf !== 1'b0) begin
      n_err++; $display("FAIL clr_vs_set: got unf %b ovf %b want 1 0", s_unf, s_ovf);
    end
    drive(1'b0, 8'h00, 1'b0);
    clr_err = 1'b0;
    n_cmp++;
    if ({s_ovf, s_unf, f_ovf, f_unf} !== {exp_ovf, exp_unf, exp_ovf, exp_unf} || exp_unf !== 1'b0) begin
      n_err++; $display("FAIL clr_err: got %b want 0000", {s_ovf, s_unf, f_ovf, f_unf});
    end
`endif
  endtask

  task automatic test_fwft_latency();
    drive(1'b1, 8'hA5, 1'b0);
    n_cmp++;
    if (f_empty !== 1'b0 || f_rd !== 8'hA5) begin
      n_err++; $display("FAIL fwft_latency: got empty %b rd %h want 0 a5", f_empty, f_rd);
    end
    n_cmp++;
    if (s_rd !== last_rd) begin
      n_err++; $display("FAIL std_hold: got %h want %h", s_rd, last_rd);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++; $display("FAIL fwft_pop_sb: got none want one");
    end else begin
      last_rd = sb_q.pop_front();
      if (s_rd !== last_rd || f_empty !== 1'b1) begin
        n_err++; $display("FAIL std_after_fwft: got rd %h empty %b want %h 1", s_rd, f_empty, last_rd);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(8'h03 + i), 1'b1);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL wrap_sb[%0d]: got none want one", i);
      end else begin
        last_rd = sb_q.pop_front();
        if (s_rd !== last_rd || s_count !== 3'd2) begin
          n_err++; $display("FAIL wrap_std[%0d]: got rd %h count %0d want %h 2", i, s_rd, s_count, last_rd);
        end
      end
      n_cmp++;
      if (f_rd !== mdl[0] || f_count !== 3'd2) begin
        n_err++; $display("FAIL wrap_fwft[%0d]: got rd %h count %0d want %h 2", i, f_rd, f_count, mdl[0]);
      end
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
    drive(1'b1, 8'hD0, 1'b1);
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++; $display("FAIL full_pp_sb: got none want one");
    end else begin
      last_rd = sb_q.pop_front();
      if (s_rd !== last_rd || s_count !== 3'd5 || s_full !== 1'b1) begin
        n_err++; $display("FAIL full_push_pop: got rd %h count %0d full %b want %h 5 1", s_rd, s_count, s_full, last_rd);
      end
    end
    n_cmp++;
    if (f_rd !== mdl[0]) begin
      n_err++; $display("FAIL full_pp_fwft: got %h want %h", f_rd, mdl[0]);
    end
    while (mdl.size() != 0) drive(1'b0, 8'h00, 1'b1);
    while (sb_q.size() != 0) last_rd = sb_q.pop_front();
    n_cmp++;
    if (s_rd !== last_rd || last_rd !== 8'hD0) begin
      n_err++; $display("FAIL wrap_drain_tail: got %h want %h", s_rd, last_rd);
    end
    drive(1'b1, 8'hE1, 1'b1);
    n_cmp++;
    if (s_count !== 3'd1 || f_count !== 3'd1 || s_rd !== last_rd || f_rd !== 8'hE1) begin
      n_err++; $display("FAIL empty_push_pop: got count %0d/%0d rd %h/%h want 1 %h e1", s_count, f_count, s_rd, f_rd, last_rd);
    end
`ifdef SYNC_FIFO_ERR_EN
    clr_err = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    clr_err = 1'b0;
`endif
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
    n_cmp++;
    if (s_count !== 3'd3) begin
      n_err++; $display("FAIL pre_reset_count: got %0d want 3", s_count);
    end
    apply_reset(1, 1'b1);
    n_cmp++;
    if ({s_empty, s_full, s_afull, s_aempty, s_count} !== exp_status(0) || f_rd !== 8'h00 || s_rd !== 8'h00) begin
      n_err++; $display("FAIL mid_reset: got %b rd %h/%h want %b 00", {s_empty, s_full, s_afull, s_aempty, s_count}, s_rd, f_rd, exp_status(0));
    end
    drive(1'b1, 8'h7E, 1'b0);
    n_cmp++;
    if (f_rd !== 8'h7E || f_count !== 3'd1) begin
      n_err++; $display("FAIL post_reset_fwft: got %h count %0d want 7e 1", f_rd, f_count);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++; $display("FAIL post_reset_sb: got none want one");
    end else begin
      last_rd = sb_q.pop_front();
      if (s_rd !== last_rd || last_rd !== 8'h7E) begin
        n_err++; $display("FAIL post_reset_std: got %h want 7e", s_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50));
      if (sb_q.size() != 0) last_rd = sb_q.pop_front();
      n_cmp++;
      if (s_rd !== last_rd || {s_empty, s_full, s_afull, s_aempty, s_count} !== exp_status(mdl.size())) begin
        n_err++; $display("FAIL random_std[%0d]: got rd %h st %b want %h %b", i, s_rd, {s_empty, s_full, s_afull, s_aempty, s_count}, last_rd, exp_status(mdl.size()));
      end
      n_cmp++;
      if ({f_empty, f_full, f_afull, f_aempty, f_count} !== exp_status(mdl.size()) ||
          (mdl.size() != 0 && f_rd !== mdl[0])) begin
        n_err++; $display("FAIL random_fwft[%0d]: got rd %h st %b want st %b", i, f_rd, {f_empty, f_full, f_afull, f_aempty, f_count}, exp_status(mdl.size()));
      end
`ifdef SYNC_FIFO_ERR_EN
      n_cmp++;
      if ({s_ovf, s_unf} !== {exp_ovf, exp_unf}) begin
        n_err++; $display("FAIL random_err[%0d]: got %b want %b", i, {s_ovf, s_unf}, {exp_ovf, exp_unf});
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_fwft_latency();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
